// File: rtl/input_conditioner_pkg.sv
// input_cond_pkg
// Shared definitions for the input conditioner: reset FSM state encoding,
// default timing parameters and a counter-width helper.
package input_cond_pkg;

  // Reset FSM states. HOLD keeps the system in reset, RUN releases it.
  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_t;

  // 10 ms at 100 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_RESET_HOLD      = 16;

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce.sv
// debounce_unit
// Debounces one already-synchronised level. A change is accepted only after
// the input has differed from the accepted level for DEBOUNCE_CYCLES
// consecutive cycles; any return to the accepted level cancels the change.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   sync_in      : synchronised raw input
//   level        : accepted (debounced) level
//   rise         : one-cycle pulse in the cycle after level goes 0->1
module debounce_unit
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic level,
  output logic rise
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync_in != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= accept && sync_in;
      if (sync_in == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_in;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
// Front-end conditioning: synchronises and debounces the exec and reset
// buttons, produces a one-cycle execute strobe with a matching switch
// snapshot, and generates a stretched, synchronously released system reset.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   btn_exec      : raw exec button
//   btn_reset     : raw reset button
//   sw            : raw slide switches
//   exec_pulse    : one-cycle strobe per accepted exec press
//   sw_snap       : synchronised switches captured with exec_pulse
//   sys_reset_n   : stretched active-low system reset
//   btn_reset_db  : debounced reset-button level
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int RESET_HOLD      = DEFAULT_RESET_HOLD,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_exec,
  input  logic                btn_reset,
  input  logic [SW_WIDTH-1:0] sw,
  output logic                exec_pulse,
  output logic [SW_WIDTH-1:0] sw_snap,
  output logic                sys_reset_n,
  output logic                btn_reset_db
);

  localparam int HOLD_W = cnt_width(RESET_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  // Two-stage synchronisers.
  logic                exec_s1, exec_s2;
  logic                rst_s1, rst_s2;
  logic [SW_WIDTH-1:0] sw_s1, sw_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_s1 <= 1'b0;
      exec_s2 <= 1'b0;
      rst_s1  <= 1'b0;
      rst_s2  <= 1'b0;
      sw_s1   <= '0;
      sw_s2   <= '0;
    end else begin
      exec_s1 <= btn_exec;
      exec_s2 <= exec_s1;
      rst_s1  <= btn_reset;
      rst_s2  <= rst_s1;
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
    end
  end

  logic exec_level, exec_rise;
  logic rst_rise;

  debounce_unit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_exec (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_in (exec_s2),
    .level   (exec_level),
    .rise    (exec_rise)
  );

  debounce_unit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_in (rst_s2),
    .level   (btn_reset_db),
    .rise    (rst_rise)
  );

  // Reset FSM.
  rst_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      HOLD: begin
        // A held button freezes the count at zero; release starts the
        // full hold period from scratch.
        if (btn_reset_db) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (rst_rise) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
    endcase
  end

  // Straight from a single flop, so the release is glitch-free and
  // synchronous to clk.
  assign sys_reset_n = (state_q == RUN);

  // Exec strobe and snapshot. An accepted press is dropped (not deferred)
  // if the system is in reset or is entering reset on this same edge.
  logic capture;
  assign capture = exec_rise && exec_level && (state_q == RUN) && !rst_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_pulse <= 1'b0;
      sw_snap    <= '0;
    end else begin
      exec_pulse <= capture;
      if (capture) begin
        sw_snap <= sw_s2;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, RESET_HOLD=3.
module tb_input_conditioner;

  localparam int DB = 4;
  localparam int RH = 3;
  localparam int SW_W = 16;

  // Clock / reset
  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            btn_exec = 1'b0;
  logic            btn_reset = 1'b0;
  logic [SW_W-1:0] sw = '0;
  logic            exec_pulse;
  logic [SW_W-1:0] sw_snap;
  logic            sys_reset_n;
  logic            btn_reset_db;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .RESET_HOLD      (RH),
    .SW_WIDTH        (SW_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_exec     (btn_exec),
    .btn_reset    (btn_reset),
    .sw           (sw),
    .exec_pulse   (exec_pulse),
    .sw_snap      (sw_snap),
    .sys_reset_n  (sys_reset_n),
    .btn_reset_db (btn_reset_db)
  );

  int vectors = 0;
  int miscompares = 0;

  // Pulse counter sampled on the falling edge, away from the active edge.
  int pulse_cnt = 0;
  always @(negedge clk) if (exec_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int base;

  initial begin
    // Power-on
    cyc(5);
    check("por_sys_reset_n", 32'(sys_reset_n), 32'd0);
    check("por_exec_pulse", 32'(exec_pulse), 32'd0);
    check("por_sw_snap", 32'(sw_snap), 32'd0);
    check("por_btn_reset_db", 32'(btn_reset_db), 32'd0);
    reset_n = 1'b1;
    cyc(1); check("por_hold_c1", 32'(sys_reset_n), 32'd0);
    cyc(1); check("por_hold_c2", 32'(sys_reset_n), 32'd0);
    cyc(1); check("por_release_c3", 32'(sys_reset_n), 32'd1);
    check("por_no_pulse", 32'(pulse_cnt), 32'd0);

    // Clean exec press
    base = pulse_cnt;
    sw = 16'hA5C3;
    btn_exec = 1'b1;
    cyc(6);
    check("exec_pre_c6", 32'(exec_pulse), 32'd0);
    check("exec_pre_cnt", 32'(pulse_cnt - base), 32'd0);
    cyc(1);
    check("exec_pulse_c7", 32'(exec_pulse), 32'd1);
    check("exec_snap_c7", 32'(sw_snap), 32'hA5C3);
    cyc(1);
    check("exec_pulse_c8", 32'(exec_pulse), 32'd0);
    sw = 16'h1234;
    cyc(12);
    btn_exec = 1'b0;
    cyc(12);
    check("exec_one_pulse", 32'(pulse_cnt - base), 32'd1);
    check("exec_snap_held", 32'(sw_snap), 32'hA5C3);

    // Bounce: 3 high, 1 low, 3 high, low
    base = pulse_cnt;
    btn_exec = 1'b1; cyc(3);
    btn_exec = 1'b0; cyc(1);
    btn_exec = 1'b1; cyc(3);
    btn_exec = 1'b0; cyc(15);
    check("bounce_no_pulse", 32'(pulse_cnt - base), 32'd0);
    check("bounce_snap", 32'(sw_snap), 32'hA5C3);

    // Reset button pressed 10 cycles in RUN
    btn_reset = 1'b1;
    cyc(5);
    check("rbtn_db_c5", 32'(btn_reset_db), 32'd0);
    check("rbtn_sys_c5", 32'(sys_reset_n), 32'd1);
    cyc(1);
    check("rbtn_db_c6", 32'(btn_reset_db), 32'd1);
    check("rbtn_sys_c6", 32'(sys_reset_n), 32'd1);
    cyc(1);
    check("rbtn_sys_c7", 32'(sys_reset_n), 32'd0);
    cyc(3);
    btn_reset = 1'b0;
    cyc(5);
    check("rbtn_db_hold", 32'(btn_reset_db), 32'd1);
    check("rbtn_sys_hold", 32'(sys_reset_n), 32'd0);
    cyc(1);
    check("rbtn_db_fall", 32'(btn_reset_db), 32'd0);
    check("rbtn_sys_fall", 32'(sys_reset_n), 32'd0);
    cyc(2);
    check("rbtn_sys_c2", 32'(sys_reset_n), 32'd0);
    cyc(1);
    check("rbtn_sys_c3", 32'(sys_reset_n), 32'd1);

    // Simultaneous exec and reset-button accept
    base = pulse_cnt;
    sw = 16'hBEEF;
    btn_exec = 1'b1;
    btn_reset = 1'b1;
    cyc(6);
    check("sim_db_c6", 32'(btn_reset_db), 32'd1);
    cyc(1);
    check("sim_pulse_c7", 32'(exec_pulse), 32'd0);
    check("sim_sys_c7", 32'(sys_reset_n), 32'd0);
    btn_reset = 1'b0;
    cyc(20);
    check("sim_sys_back", 32'(sys_reset_n), 32'd1);
    btn_exec = 1'b0;
    cyc(10);
    check("sim_no_pulse", 32'(pulse_cnt - base), 32'd0);
    check("sim_snap_kept", 32'(sw_snap), 32'hA5C3);

    // Async reset mid-debounce (counter at 2)
    base = pulse_cnt;
    btn_exec = 1'b1;
    cyc(4);
    reset_n = 1'b0;
    btn_exec = 1'b0;
    #1;
    check("arst_sys_now", 32'(sys_reset_n), 32'd0);
    check("arst_snap_now", 32'(sw_snap), 32'd0);
    check("arst_db_now", 32'(btn_reset_db), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1); check("arst_hold_c1", 32'(sys_reset_n), 32'd0);
    cyc(1); check("arst_hold_c2", 32'(sys_reset_n), 32'd0);
    cyc(1); check("arst_release_c3", 32'(sys_reset_n), 32'd1);
    cyc(10);
    check("arst_no_pulse", 32'(pulse_cnt - base), 32'd0);

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
